// File: rtl/mem_arbiter.sv
// Arbitrates one RAM port between instruction fetch and data access.
// Data wins by default; a fetch is forced through after MAX_D_STREAK data grants.
module mem_arbiter #(
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ready,
    output logic        timeout
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [CW-1:0] ACC_LAST = CW'(TIMEOUT - 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        I_ACC = 2'd1,
        D_ACC = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] d_streak_q, d_streak_d;
    logic [CW-1:0] acc_cnt_q, acc_cnt_d;
    logic          timeout_q, timeout_d;
    logic          d_req;

    assign d_req = dREN | dWEN;

    always_comb begin
        state_d    = state_q;
        d_streak_d = d_streak_q;
        acc_cnt_d  = acc_cnt_q;
        timeout_d  = 1'b0;
        case (state_q)
            IDLE: begin
                acc_cnt_d = '0;
                if (d_req && (!iREN || (d_streak_q < STREAK_MAX))) begin
                    state_d = D_ACC;
                    if (!iREN)
                        d_streak_d = '0;
                    else if (d_streak_q != STREAK_MAX)
                        d_streak_d = d_streak_q + 1'b1;
                end else if (iREN) begin
                    state_d    = I_ACC;
                    d_streak_d = '0;
                end
            end
            I_ACC: begin
                // Withdrawal and completion both end the access without a timeout.
                if (!iREN || ram_ready) begin
                    state_d = IDLE;
                end else if (acc_cnt_q == ACC_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    acc_cnt_d = acc_cnt_q + 1'b1;
                end
            end
            D_ACC: begin
                if (!d_req || ram_ready) begin
                    state_d = IDLE;
                end else if (acc_cnt_q == ACC_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    acc_cnt_d = acc_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            d_streak_q <= '0;
            acc_cnt_q  <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            d_streak_q <= d_streak_d;
            acc_cnt_q  <= acc_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // RAM side follows the live requester inputs so a dropped request kills the strobe at once.
    assign ramREN   = ((state_q == I_ACC) && iREN) || ((state_q == D_ACC) && dREN && !dWEN);
    assign ramWEN   = (state_q == D_ACC) && dWEN;
    assign ramaddr  = (state_q == I_ACC) ? iaddr : ((state_q == D_ACC) ? daddr : 32'h0);
    assign ramstore = (state_q == D_ACC) ? dstore : 32'h0;

    assign iwait   = iREN  & ~((state_q == I_ACC) & ram_ready);
    assign dwait   = d_req & ~((state_q == D_ACC) & ram_ready);
    assign iload   = ramload;
    assign dload   = ramload;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus sequences for
// starvation, timeout and mid-access reset.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN, ram_ready;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        iwait, dwait, ramREN, ramWEN, timeout;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.MAX_D_STREAK(4), .TIMEOUT(64)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ram_ready(ram_ready), .timeout(timeout)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst, i_ren, d_ren, d_wen, rdy;
        logic [31:0] i_addr, d_addr, d_store, r_load;
        logic        e_ren, e_wen;
        logic [31:0] e_addr, e_store;
        logic        e_iwait, e_dwait, e_to;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic r, input logic ir, input logic dr, input logic dw,
                         input logic rd, input logic [31:0] ia, input logic [31:0] da,
                         input logic [31:0] ds, input logic [31:0] rl);
        RST = r; iREN = ir; dREN = dr; dWEN = dw; ram_ready = rd;
        iaddr = ia; daddr = da; dstore = ds; ramload = rl;
    endtask

    // 0 = idle, 1 = data grant, 2 = fetch grant, judged from the RAM side
    function automatic int grant_class();
        if (!(ramREN || ramWEN)) return 0;
        if (ramaddr == 32'h300) return 1;
        if (ramaddr == 32'h400) return 2;
        return 3;
    endfunction

    // Both requesters saturating the port with instant RAM: D,D,D,D,I repeating.
    task automatic starve(input string tag);
        int d_before_i = 0;
        bit seen_i = 0;
        drive(0, 1, 1, 0, 1, 32'h400, 32'h300, 32'h0, 32'h0);
        for (int k = 0; k < 20; k++) begin
            int exp_c;
            #2;
            if (k % 2 == 0) exp_c = 0;
            else exp_c = (((k - 1) / 2) % 5 == 4) ? 2 : 1;
            chk($sformatf("%s_grant_k%0d", tag, k), 32'(grant_class()), 32'(exp_c));
            if (grant_class() == 2) seen_i = 1;
            if (grant_class() == 1 && !seen_i) d_before_i++;
            tick();
        end
        chk({tag, "_d_before_first_i"}, 32'(d_before_i), 32'd4);
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        tick();
    endtask

    initial begin
        vecs[0]  = '{1,1,0,0,0, 32'h40,32'h0,32'h0,32'h0,              0,0,32'h0,32'h0,    1,0,0};
        vecs[1]  = '{0,1,0,0,0, 32'h40,32'h0,32'h0,32'h0,              0,0,32'h0,32'h0,    1,0,0};
        vecs[2]  = '{0,1,0,0,0, 32'h40,32'h0,32'h0,32'h0,              1,0,32'h40,32'h0,   1,0,0};
        vecs[3]  = '{0,1,0,0,1, 32'h40,32'h0,32'h0,32'hDEADBEEF,       1,0,32'h40,32'h0,   0,0,0};
        vecs[4]  = '{0,0,0,0,0, 32'h0,32'h0,32'h0,32'h0,               0,0,32'h0,32'h0,    0,0,0};
        vecs[5]  = '{0,1,1,1,0, 32'h44,32'h100,32'h5,32'h0,            0,0,32'h0,32'h0,    1,1,0};
        vecs[6]  = '{0,1,1,1,1, 32'h44,32'h100,32'h5,32'h0,            0,1,32'h100,32'h5,  1,0,0};
        vecs[7]  = '{0,1,0,0,0, 32'h44,32'h0,32'h0,32'h0,              0,0,32'h0,32'h0,    1,0,0};
        vecs[8]  = '{0,1,0,0,1, 32'h44,32'h0,32'h0,32'h1234,           1,0,32'h44,32'h0,   0,0,0};
        vecs[9]  = '{0,0,0,0,0, 32'h0,32'h0,32'h0,32'h0,               0,0,32'h0,32'h0,    0,0,0};
        vecs[10] = '{0,1,0,0,0, 32'h80,32'h0,32'h0,32'h0,              0,0,32'h0,32'h0,    1,0,0};
        vecs[11] = '{0,1,0,0,0, 32'h80,32'h0,32'h0,32'h0,              1,0,32'h80,32'h0,   1,0,0};
        vecs[12] = '{0,0,0,0,1, 32'h80,32'h0,32'h0,32'h0,              0,0,32'h80,32'h0,   0,0,0};
        vecs[13] = '{0,1,0,0,1, 32'h80,32'h0,32'h0,32'h0,              0,0,32'h0,32'h0,    1,0,0};
        vecs[14] = '{0,1,0,0,1, 32'h80,32'h0,32'h0,32'hCAFE,           1,0,32'h80,32'h0,   0,0,0};
        vecs[15] = '{0,0,0,0,0, 32'h0,32'h0,32'h0,32'h0,               0,0,32'h0,32'h0,    0,0,0};
        vecs[16] = '{0,0,1,0,0, 32'h0,32'h200,32'h77,32'h0,            0,0,32'h0,32'h0,    0,1,0};
        vecs[17] = '{0,0,1,0,1, 32'h0,32'h200,32'h77,32'hABCD,         1,0,32'h200,32'h77, 0,0,0};
        vecs[18] = '{0,0,0,0,0, 32'h0,32'h0,32'h0,32'h0,               0,0,32'h0,32'h0,    0,0,0};

        drive(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        tick();

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].rst, vecs[i].i_ren, vecs[i].d_ren, vecs[i].d_wen, vecs[i].rdy,
                  vecs[i].i_addr, vecs[i].d_addr, vecs[i].d_store, vecs[i].r_load);
            #2;
            chk($sformatf("v%0d_ramREN", i),   32'(ramREN),  32'(vecs[i].e_ren));
            chk($sformatf("v%0d_ramWEN", i),   32'(ramWEN),  32'(vecs[i].e_wen));
            chk($sformatf("v%0d_ramaddr", i),  ramaddr,      vecs[i].e_addr);
            chk($sformatf("v%0d_ramstore", i), ramstore,     vecs[i].e_store);
            chk($sformatf("v%0d_iwait", i),    32'(iwait),   32'(vecs[i].e_iwait));
            chk($sformatf("v%0d_dwait", i),    32'(dwait),   32'(vecs[i].e_dwait));
            chk($sformatf("v%0d_timeout", i),  32'(timeout), 32'(vecs[i].e_to));
            chk($sformatf("v%0d_iload", i),    iload,        vecs[i].r_load);
            chk($sformatf("v%0d_dload", i),    dload,        vecs[i].r_load);
            tick();
        end

        starve("starve1");

        // Timeout: 64 stalled access cycles, a one-cycle pulse in IDLE, then a retry.
        drive(0, 0, 1, 0, 0, 32'h0, 32'h500, 32'h0, 32'h0);
        for (int k = 0; k < 67; k++) begin
            #2;
            chk($sformatf("to_ramREN_k%0d", k), 32'(ramREN),
                32'(((k >= 1) && (k <= 64)) || (k == 66)));
            chk($sformatf("to_pulse_k%0d", k), 32'(timeout), 32'(k == 65));
            chk($sformatf("to_dwait_k%0d", k), 32'(dwait), 32'd1);
            tick();
        end
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        #2;
        chk("to_withdraw_ramREN", 32'(ramREN), 32'd0);
        tick();
        tick();

        // Reset during a stalled data write; streak built to 1 beforehand.
        drive(0, 1, 0, 1, 0, 32'h0, 32'h600, 32'h9, 32'h0);
        tick();
        #2;
        chk("rst_pre_ramWEN", 32'(ramWEN), 32'd1);
        chk("rst_pre_ramaddr", ramaddr, 32'h600);
        RST = 1'b1;
        tick();
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        #2;
        chk("rst_post_ramWEN", 32'(ramWEN), 32'd0);
        chk("rst_post_ramREN", 32'(ramREN), 32'd0);
        chk("rst_post_ramaddr", ramaddr, 32'h0);
        chk("rst_post_timeout", 32'(timeout), 32'd0);
        tick();
        starve("starve2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
